// File: rtl/vj_ctrl_pkg.sv
// Shared control types and defaults for the Viola-Jones scan scheduler.
package vj_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_INT,
    ST_SCAN,
    ST_DRAIN
  } scan_state_e;

  localparam int WAIT_CYCLES_DEF  = 10;
  localparam int DRAIN_CYCLES_DEF = 16;

  // Level index presented whenever no window is being scanned.
  localparam logic [3:0] IMG_IDLE = 4'd15;

  function automatic logic level_usable(input logic [31:0] w, input logic [31:0] h,
                                        input logic [31:0] win);
    return (w >= win + 32'd1) && (h >= win + 32'd1);
  endfunction

endpackage

// File: rtl/scan_scheduler_level_walker.sv
// Raster row/col counter for one pyramid level; wrap marks the final window.
module level_walker (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        advance_i,
  input  logic [31:0] last_row_i,
  input  logic [31:0] last_col_i,
  output logic [31:0] row_o,
  output logic [31:0] col_o,
  output logic        wrap_o
);

  logic [31:0] row_q, row_d;
  logic [31:0] col_q, col_d;
  logic        col_end;
  logic        row_end;

  assign col_end = (col_q >= last_col_i);
  assign row_end = (row_q >= last_row_i);
  assign wrap_o  = advance_i && col_end && row_end;
  assign row_o   = row_q;
  assign col_o   = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance_i) begin
      if (!col_end) begin
        col_d = col_q + 32'd1;
      end else begin
        col_d = 32'd0;
        row_d = row_end ? 32'd0 : row_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      row_q <= 32'd0;
      col_q <= 32'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/vj_weights.vh
// Default image-pyramid geometry for the Viola-Jones window scanner.
`ifndef VJ_WEIGHTS_VH
`define VJ_WEIGHTS_VH

`define PYRAMID_LEVELS  3
`define WINDOW_SIZE     24
`define PYRAMID_WIDTHS  {32'd80, 32'd100, 32'd128}
`define PYRAMID_HEIGHTS {32'd60, 32'd75, 32'd96}

`endif

// File: rtl/scan_scheduler.sv
// Walks every usable pyramid level in raster order, handing windows to the
// classifier pipeline, then waits for the pipeline to drain.
`include "vj_weights.vh"

module scan_scheduler
  import vj_ctrl_pkg::*;
#(
  parameter int                      LEVELS       = `PYRAMID_LEVELS,
  parameter int                      WIN          = `WINDOW_SIZE,
  parameter logic [LEVELS-1:0][31:0] WIDTHS       = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0] HEIGHTS      = `PYRAMID_HEIGHTS,
  parameter int                      WAIT_CYCLES  = WAIT_CYCLES_DEF,
  parameter int                      DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        win_ready,
  output logic        win_valid,
  output logic [3:0]  img_index,
  output logic [31:0] row_index,
  output logic [31:0] col_index,
  output logic        busy,
  output logic        level_done,
  output logic        frame_done,
  output logic [31:0] win_count
);

  localparam logic [31:0] WIN_U   = 32'(WIN);
  localparam logic [31:0] WAIT_U  = 32'(WAIT_CYCLES);
  localparam logic [31:0] DRAIN_U = 32'(DRAIN_CYCLES);

  scan_state_e state_q;
  logic [31:0] cnt_q;
  logic        win_valid_q;
  logic [3:0]  img_q;
  logic        busy_q;
  logic        level_done_q;
  logic        frame_done_q;
  logic [31:0] win_count_q;

  logic [LEVELS-1:0] usable_lvl;
  logic [31:0]       last_row_tbl [LEVELS];
  logic [31:0]       last_col_tbl [LEVELS];
  logic [31:0]       last_row;
  logic [31:0]       last_col;
  logic [3:0]        first_lvl;
  logic [3:0]        next_lvl;
  logic              accept;
  logic              wrap;

  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
      assign usable_lvl[gi]   = level_usable(WIDTHS[gi], HEIGHTS[gi], WIN_U);
      assign last_col_tbl[gi] = WIDTHS[gi] - WIN_U - 32'd1;
      assign last_row_tbl[gi] = HEIGHTS[gi] - WIN_U - 32'd1;
    end
  endgenerate

  always_comb begin
    last_row = 32'd0;
    last_col = 32'd0;
    for (int l = 0; l < LEVELS; l++) begin
      if (img_q == 4'(l)) begin
        last_row = last_row_tbl[l];
        last_col = last_col_tbl[l];
      end
    end
  end

  // Descending scan leaves the lowest matching level in each result.
  always_comb begin
    first_lvl = IMG_IDLE;
    next_lvl  = IMG_IDLE;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      if (usable_lvl[l]) begin
        first_lvl = 4'(l);
        if (4'(l) > img_q) next_lvl = 4'(l);
      end
    end
  end

  assign accept = win_valid_q && win_ready;

  level_walker u_walker (
    .clk_i      (clock),
    .srst_i     (reset),
    .advance_i  (accept),
    .last_row_i (last_row),
    .last_col_i (last_col),
    .row_o      (row_index),
    .col_o      (col_index),
    .wrap_o     (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      win_valid_q  <= 1'b0;
      img_q        <= IMG_IDLE;
      busy_q       <= 1'b0;
      level_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      win_count_q  <= 32'd0;
    end else begin
      level_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A start landing on the frame_done cycle belongs to the old frame.
          if (start && !frame_done_q) begin
            state_q     <= ST_WAIT_INT;
            cnt_q       <= 32'd0;
            win_count_q <= 32'd0;
            busy_q      <= 1'b1;
          end
        end
        ST_WAIT_INT: begin
          if (cnt_q + 32'd1 >= WAIT_U) begin
            cnt_q <= 32'd0;
            if (first_lvl != IMG_IDLE) begin
              state_q     <= ST_SCAN;
              img_q       <= first_lvl;
              win_valid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            win_count_q <= win_count_q + 32'd1;
            if (wrap) begin
              level_done_q <= 1'b1;
              if (next_lvl != IMG_IDLE) begin
                img_q <= next_lvl;
              end else begin
                state_q     <= ST_DRAIN;
                img_q       <= IMG_IDLE;
                win_valid_q <= 1'b0;
                cnt_q       <= 32'd0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q + 32'd1 >= DRAIN_U) begin
            cnt_q        <= 32'd0;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign win_valid  = win_valid_q;
  assign img_index  = img_q;
  assign busy       = busy_q;
  assign level_done = level_done_q;
  assign frame_done = frame_done_q;
  assign win_count  = win_count_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Scoreboard bench: stimulus queues expected windows, monitors pop on accept.
module tb_scan_scheduler;

  typedef struct {
    logic [3:0]  img;
    logic [31:0] row;
    logic [31:0] col;
  } win_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        win_ready = 1'b1;
  logic        win_valid, busy, level_done, frame_done;
  logic [3:0]  img_index;
  logic [31:0] row_index, col_index, win_count;

  logic        start_b = 1'b0;
  logic        win_valid_b, busy_b, level_done_b, frame_done_b;
  logic [3:0]  img_index_b;
  logic [31:0] row_index_b, col_index_b, win_count_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_acc = 0;
  int ld_cnt = 0;
  int ld_cnt_b = 0;
  bit tog = 1'b0;
  win_t q[$];
  win_t qb[$];

  // Hand-computed raster: level0 5x4 -> 3 cols x 2 rows, level1 4x3 -> 2 cols x 1 row.
  int exp_tbl [8][3] = '{'{0,0,0}, '{0,0,1}, '{0,0,2}, '{0,1,0},
                         '{0,1,1}, '{0,1,2}, '{1,0,0}, '{1,0,1}};

  scan_scheduler #(
    .LEVELS(2), .WIN(2),
    .WIDTHS({32'd4, 32'd5}), .HEIGHTS({32'd3, 32'd4}),
    .WAIT_CYCLES(3), .DRAIN_CYCLES(4)
  ) dut (
    .clock(clk), .reset(rst), .start(start), .win_ready(win_ready),
    .win_valid(win_valid), .img_index(img_index), .row_index(row_index),
    .col_index(col_index), .busy(busy), .level_done(level_done),
    .frame_done(frame_done), .win_count(win_count)
  );

  // Level 0 shrunk to 2x2 so it cannot hold a window.
  scan_scheduler #(
    .LEVELS(2), .WIN(2),
    .WIDTHS({32'd4, 32'd2}), .HEIGHTS({32'd3, 32'd2}),
    .WAIT_CYCLES(3), .DRAIN_CYCLES(4)
  ) dut_skip (
    .clock(clk), .reset(rst), .start(start_b), .win_ready(1'b1),
    .win_valid(win_valid_b), .img_index(img_index_b), .row_index(row_index_b),
    .col_index(col_index_b), .busy(busy_b), .level_done(level_done_b),
    .frame_done(frame_done_b), .win_count(win_count_b)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk);
    #1;
    win_ready = tog ? ~win_ready : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Monitor for the main instance: hold check while stalled, pop on accept.
  initial begin
    bit   stall_prev = 1'b0;
    win_t held;
    win_t e;
    forever begin
      @(negedge clk);
      if (stall_prev && win_valid) begin
        check("hold_img", 32'(img_index), 32'(held.img));
        check("hold_row", row_index, held.row);
        check("hold_col", col_index, held.col);
      end
      if (win_valid && win_ready) begin
        if (q.size() == 0) begin
          check("queue_empty_on_accept", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("win_img", 32'(img_index), 32'(e.img));
          check("win_row", row_index, e.row);
          check("win_col", col_index, e.col);
        end
        last_acc = cyc + 1;
      end
      if (level_done) ld_cnt++;
      stall_prev = win_valid && !win_ready;
      held.img = img_index;
      held.row = row_index;
      held.col = col_index;
    end
  end

  // Monitor for the level-skip instance (always ready).
  initial begin
    win_t e;
    forever begin
      @(negedge clk);
      if (win_valid_b) begin
        if (qb.size() == 0) begin
          check("skip_queue_empty_on_accept", 32'(qb.size()), 32'd1);
        end else begin
          e = qb.pop_front();
          check("skip_img", 32'(img_index_b), 32'(e.img));
          check("skip_row", row_index_b, e.row);
          check("skip_col", col_index_b, e.col);
        end
      end
      if (level_done_b) ld_cnt_b++;
    end
  end

  task automatic push_frame(input int count);
    win_t w;
    for (int i = 0; i < count; i++) begin
      w.img = 4'(exp_tbl[i][0]);
      w.row = 32'(exp_tbl[i][1]);
      w.col = 32'(exp_tbl[i][2]);
      q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit extra_start);
    int n;
    push_frame(8);
    ld_cnt = 0;
    pulse_start();
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_valid_low", 32'(win_valid), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("valid_low_2_cycles", 32'(win_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("valid_high_3_cycles", 32'(win_valid), 32'd1);
    if (extra_start) pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 300);
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("drain_latency", 32'(cyc - last_acc), 32'd4);
    check("level_done_pulses", 32'(ld_cnt), 32'd2);
    check("win_count", win_count, 32'd8);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("img_after_frame", 32'(img_index), 32'd15);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    win_t w;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(win_valid), 32'd0);
    check("rst_img", 32'(img_index), 32'd15);
    check("rst_row", row_index, 32'd0);
    check("rst_col", col_index, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level_done", 32'(level_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_win_count", win_count, 32'd0);

    // Full frame, always ready; then start on the frame_done cycle.
    run_frame(1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("start_on_frame_done_busy", 32'(busy), 32'd0);
    end

    // Backpressure: ready toggles every cycle.
    tog = 1'b1;
    run_frame(1'b0);
    tog = 1'b0;

    // Second start pulse mid-scan is ignored.
    run_frame(1'b1);

    // Reset lands on the 4th accept.
    push_frame(4);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!win_valid && n < 50);
    check("scan_reached", 32'(win_valid), 32'd1);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midscan_rst_img", 32'(img_index), 32'd15);
    check("midscan_rst_valid", 32'(win_valid), 32'd0);
    check("midscan_rst_busy", 32'(busy), 32'd0);
    check("midscan_rst_count", win_count, 32'd0);
    check("midscan_rst_row", row_index, 32'd0);
    check("midscan_rst_col", col_index, 32'd0);
    check("midscan_queue", 32'(q.size()), 32'd0);
    run_frame(1'b0);

    // Unusable level 0 is skipped.
    for (int i = 6; i < 8; i++) begin
      w.img = 4'(exp_tbl[i][0]);
      w.row = 32'(exp_tbl[i][1]);
      w.col = 32'(exp_tbl[i][2]);
      qb.push_back(w);
    end
    ld_cnt_b = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done_b && n < 300);
    check("skip_frame_done_seen", 32'(frame_done_b), 32'd1);
    check("skip_level_done_pulses", 32'(ld_cnt_b), 32'd1);
    check("skip_win_count", win_count_b, 32'd2);
    check("skip_queue_drained", 32'(qb.size()), 32'd0);
    check("skip_busy_after", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_scheduler.md
SCAN_SCHEDULER -- requirements
Module: scan_scheduler

Interface
REQ-001 SHALL have parameter LEVELS, default `PYRAMID_LEVELS, number of pyramid levels scanned.
REQ-002 SHALL have parameter WIN, default `WINDOW_SIZE, scanning-window edge in pixels.
REQ-003 SHALL have parameter WIDTHS, default `PYRAMID_WIDTHS, packed [LEVELS-1:0][31:0] per-level image widths.
REQ-004 SHALL have parameter HEIGHTS, default `PYRAMID_HEIGHTS, packed [LEVELS-1:0][31:0] per-level image heights.
REQ-005 SHALL have parameter WAIT_CYCLES, default 10, integral-image settle time after start.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 16, vj_pipeline latency to flush after the last window.
REQ-007 SHALL have port clock  input  1  single clock, rising edge; reset is synchronous and active-high.
REQ-008 SHALL have port reset  input  1  synchronous active-high reset.
REQ-009 SHALL have port start  input  1  one-cycle pulse: new image loaded (laptop_img_rdy).
REQ-010 SHALL have port win_ready  input  1  vj_pipeline accepts a window this cycle.
REQ-011 SHALL have port win_valid  output  1  img_index/row_index/col_index describe a valid window.
REQ-012 SHALL have port img_index  output  4  current pyramid level; 4'd15 when not scanning.
REQ-013 SHALL have port row_index  output  32  window top row.
REQ-014 SHALL have port col_index  output  32  window left column.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port level_done  output  1  one-cycle pulse when the last window of a level is accepted.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse when DRAIN completes.
REQ-018 SHALL have port win_count  output  32  windows accepted since the last start.

Function
REQ-019 SHALL implement states IDLE, WAIT_INT, SCAN, DRAIN; all state changes occur on the rising clock edge.
REQ-020 IDLE: start=1 -> WAIT_INT, wait counter=0, win_count=0.
REQ-021 WAIT_INT: count WAIT_CYCLES cycles, then enter SCAN with img_index=first usable level, row=col=0.
REQ-022 A level is usable iff WIDTHS[l] >= WIN+1 and HEIGHTS[l] >= WIN+1; unusable levels SHALL be skipped without issuing windows or pulsing level_done.
REQ-023 If no level is usable, WAIT_INT SHALL go directly to DRAIN.
REQ-024 SCAN: win_valid=1; indices SHALL hold while win_valid&&!win_ready.
REQ-025 On accept (win_valid&&win_ready): win_count+1; if col < WIDTHS[l]-WIN-1, col+1.
REQ-026 On accept with col at its last value and row < HEIGHTS[l]-WIN-1: col=0, row+1.
REQ-027 On accept at the last row and last col: pulse level_done, row=col=0, advance to the next usable level; if none remains, enter DRAIN.
REQ-028 DRAIN: win_valid=0, img_index=15, count DRAIN_CYCLES cycles, then pulse frame_done and enter IDLE.
REQ-029 start SHALL be ignored in every state except IDLE.
REQ-030 If start and frame_done coincide, start SHALL be ignored; frame_done precedes the return to IDLE.
REQ-031 Outside SCAN: win_valid=0, img_index=4'd15, row_index=col_index=0.
REQ-032 Index comparisons SHALL be 32-bit unsigned.
REQ-033 win_count SHALL wrap modulo 2^32.

Reset
REQ-034 reset SHALL force IDLE on the next edge and override all other inputs, including mid-SCAN.
REQ-035 Reset values: win_valid=0, img_index=4'd15, row_index=0, col_index=0, busy=0, level_done=0, frame_done=0, win_count=0, internal counters=0.

Structure
REQ-036 The state enum and the WAIT_CYCLES/DRAIN_CYCLES defaults SHALL live in a shared package vj_ctrl_pkg; WIDTHS, HEIGHTS, LEVELS and WIN come from vj_weights.vh.
REQ-037 SHALL contain one sub-module, level_walker: a row/col raster counter with inputs advance and the level's last row/col, and output wrap.
REQ-038 All outputs SHALL be registered.

Verification
(Bench config for scenarios: LEVELS=2, WIN=2, WIDTHS={4,5}, HEIGHTS={3,4} (level0 5x4, level1 4x3), WAIT_CYCLES=3, DRAIN_CYCLES=4.)
REQ-039 start pulse, win_ready=1 -> win_valid rises 3 cycles after WAIT_INT entry; level 0 emits (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); level 1 emits (0,0),(0,1); level_done pulses twice; frame_done 4 cycles after the last accept; win_count=8.
REQ-040 win_ready toggles 1,0,1,0 -> each index is held while win_ready=0; the same 8-window sequence is produced with no duplicates or skips.
REQ-041 Second start pulse during SCAN -> ignored; sequence and win_count=8 unchanged.
REQ-042 reset asserted at the 4th accept -> next cycle img_index=15, win_valid=0, busy=0, win_count=0; a new start restarts at level 0 (0,0).
REQ-043 Level 0 set to 2x2 (unusable) -> level 0 skipped; only the 2 level-1 windows issue; level_done pulses once.
REQ-044 start asserted in the frame_done cycle -> ignored; block stays in IDLE.
